alu_seq_ctrl: RTL and testbench

- Sequencing controller for the ALU slice: add, subtract and multiply over one shared W-bit ripple adder with carry-in and carry-out.
- Add and subtract complete in one execute cycle.
- Multiply is unsigned shift-and-add, one multiplier bit per cycle.
- Sits between the operand/opcode source and the result consumer, using a start/busy/done handshake.

---
 rtl/alu_seq_ctrl_if.sv | 17 +
 rtl/alu_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_if.sv
// Operand/opcode request and result bundle for alu_seq_ctrl.
// master: requester, which drives start/op/a/b. slave: the controller.
interface alu_seq_ctrl_if #(
   parameter int W = 8
);
   logic           start;
   logic [1:0]     op;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*W-1:0] res;
   logic           carry;

   modport master (output start, op, a, b, input busy, done, res, carry);
   modport slave  (input start, op, a, b, output busy, done, res, carry);
endinterface

// File: rtl/alu_seq_ctrl.sv
// Add/sub/mul sequencer over one shared W-bit ripple adder, start/busy/done handshake.
// Optional macro ALU_SEQ_ZERO_SKIP_EN: a multiply with a zero operand goes straight to DONE.
module alu_seq_ctrl #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   alu_seq_ctrl_if.slave alu,
   output logic [1:0]   state_o
);
   // Handshake: start is sampled only in IDLE. busy is high in EXEC and MUL.
   // done pulses high for the single DONE cycle. res and carry hold their value until the next completion.
   localparam int CW = $clog2(W) + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2, DONE = 2'd3} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   a_q, b_q, hi_q, lo_q;
   logic [1:0]     op_q;
   logic [CW-1:0]  cnt_q;
   logic [2*W-1:0] res_q;
   logic           carry_q;
   logic           busy_c, done_c;
   logic           zero_skip;
   logic [W-1:0]   add_x, add_y;
   logic           add_cin;
   logic [W:0]     sum;

`ifdef ALU_SEQ_ZERO_SKIP_EN
   assign zero_skip = (alu.a == '0) || (alu.b == '0);
`else
   assign zero_skip = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (alu.start) begin
            if (alu.op == 2'b10) state_d = zero_skip ? DONE : MUL;
            else                 state_d = EXEC;
         end
         EXEC:    state_d = DONE;
         MUL:     if (cnt_q == CW'(W - 1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_c = 1'b0;
      done_c = 1'b0;
      case (state_q)
         EXEC, MUL: busy_c = 1'b1;
         DONE:      done_c = 1'b1;
         default:   ;
      endcase
   end

   // One adder serves both paths: a +/- b in EXEC, hi + (lo[0] ? a : 0) in MUL.
   always_comb begin
      add_x   = hi_q;
      add_y   = '0;
      add_cin = 1'b0;
      if (state_q == EXEC) begin
         add_x   = a_q;
         add_y   = (op_q == 2'b01) ? ~b_q : b_q;
         add_cin = (op_q == 2'b01);
      end else if (lo_q[0]) begin
         add_y = a_q;
      end
   end

   assign sum = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (alu.start) begin
               a_q   <= alu.a;
               b_q   <= alu.b;
               op_q  <= alu.op;
               hi_q  <= '0;
               lo_q  <= alu.b;
               cnt_q <= '0;
               if (alu.op == 2'b10 && zero_skip) begin
                  res_q   <= '0;
                  carry_q <= 1'b0;
               end
            end
            EXEC: begin
               if (op_q == 2'b11) begin
                  res_q   <= '0;
                  carry_q <= 1'b0;
               end else begin
                  res_q   <= {{W{1'b0}}, sum[W-1:0]};
                  carry_q <= sum[W];
               end
            end
            MUL: begin
               // {hi,lo} shifts right by one, taking the adder's carry-out in at the top.
               hi_q  <= sum[W:1];
               lo_q  <= {sum[0], lo_q[W-1:1]};
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(W - 1)) begin
                  res_q   <= {sum, lo_q[W-1:1]};
                  carry_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign alu.busy  = busy_c;
   assign alu.done  = done_c;
   assign alu.res   = res_q;
   assign alu.carry = carry_q;
   assign state_o   = state_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl (W=8): latency, results, held start, async abort, zero multiply.
module tb_alu_seq_ctrl;
   localparam int W = 8;

   logic       clk;
   logic       rst;
   logic [1:0] state;
   int         n_checks = 0;
   int         n_err = 0;
   int         lat;

   alu_seq_ctrl_if #(.W(W)) bus ();

   alu_seq_ctrl #(.W(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .alu     (bus),
      .state_o (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive a request just after edge k, then count edges until done shows.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                         input int exp_lat, input logic [15:0] exp_res, input logic exp_carry);
      int n;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (i == 1) begin
            bus.start = 1'b0;
            chk({tag, "_busy"}, 32'(bus.busy), 32'(exp_lat > 1));
         end
         if (bus.done) begin
            n = i;
            break;
         end
      end
      chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
      chk({tag, "_res"}, 32'(bus.res), 32'(exp_res));
      chk({tag, "_carry"}, 32'(bus.carry), 32'(exp_carry));
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_outs", {14'd0, bus.res, bus.busy, bus.done}, 32'd0);
      chk("reset_carry", 32'(bus.carry), 32'd0);
      rst = 1'b0;

      run_op("add_200_100", 2'b00, 8'd200, 8'd100, 2, 16'h002C, 1'b1);
      run_op("add_255_1",   2'b00, 8'd255, 8'd1,   2, 16'h0000, 1'b1);
      run_op("add_3_4",     2'b00, 8'd3,   8'd4,   2, 16'h0007, 1'b0);
      run_op("sub_5_7",     2'b01, 8'd5,   8'd7,   2, 16'h00FE, 1'b0);
      run_op("sub_7_5",     2'b01, 8'd7,   8'd5,   2, 16'h0002, 1'b1);
      run_op("sub_9_9",     2'b01, 8'd9,   8'd9,   2, 16'h0000, 1'b1);
      run_op("reserved",    2'b11, 8'd9,   8'd4,   2, 16'h0000, 1'b0);
      run_op("mul_255_255", 2'b10, 8'd255, 8'd255, 9, 16'hFE01, 1'b0);
      run_op("mul_13_11",   2'b10, 8'd13,  8'd11,  9, 16'h008F, 1'b0);
`ifdef ALU_SEQ_ZERO_SKIP_EN
      run_op("mul_0_9",     2'b10, 8'd0,   8'd9,   1, 16'h0000, 1'b0);
`else
      run_op("mul_0_9",     2'b10, 8'd0,   8'd9,   9, 16'h0000, 1'b0);
`endif

      // start held high through a mul with operands changing every cycle
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = 2'b10; bus.a = 8'd3; bus.b = 8'd4;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         bus.a = 8'(i + 20); bus.b = 8'(i * 3 + 1); bus.op = 2'(i);
         if (bus.done) begin
            lat = i;
            break;
         end
      end
      chk("hold_lat", 32'(lat), 32'd9);
      chk("hold_res", 32'(bus.res), 32'd12);
      bus.op = 2'b00; bus.a = 8'd2; bus.b = 8'd5;
      @(posedge clk); #1;
      chk("hold_not_accepted", {29'd0, state, bus.busy}, 32'd0);
      @(posedge clk); #1;
      chk("hold_accept_idle", {29'd0, state, bus.busy}, {29'd0, 2'd1, 1'b1});
      bus.start = 1'b0;
      @(posedge clk); #1;
      chk("hold_second_done", 32'(bus.done), 32'd1);
      chk("hold_second_res", 32'(bus.res), 32'd7);

      // async reset four iterations into a multiply
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = 2'b10; bus.a = 8'd255; bus.b = 8'd255;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("pre_abort_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_state", 32'(state), 32'd0);
      chk("abort_outs", {14'd0, bus.res, bus.busy, bus.done}, 32'd0);
      chk("abort_carry", 32'(bus.carry), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      lat = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (bus.done) lat++;
      end
      chk("abort_no_done", 32'(lat), 32'd0);
      run_op("add_1_1", 2'b00, 8'd1, 8'd1, 2, 16'h0002, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
